// File: rtl/hdc_feeder_pkg.sv
// Shared types and helpers for the mapper input feeder: FSM state encoding,
// default symbol width and the window-length clamp.
package hdc_feeder_pkg;

   localparam int SYM_WIDTH        = 6;
   localparam int MAX_WINDOW1_SIZE = 12;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } feeder_state_e;

   // A zero-length window still needs one drain cycle; oversize requests saturate.
   function automatic logic [5:0] clamp_window(input logic [5:0] size, input logic [5:0] max_size);
      if (size == 6'd0) begin
         return 6'd1;
      end
      if (size > max_size) begin
         return max_size;
      end
      return size;
   endfunction

endpackage

// File: rtl/symbol_fifo.sv
// Synchronous FIFO holding {last, data} host entries; extra pointer bit
// separates full from empty.
module symbol_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 7
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             soft_reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (!soft_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/input_feeder.sv
// Feeds buffered host symbols to the mapper, pacing issue by the mapper's
// ready pulses in sliding-window mode and draining the final window.
module input_feeder
   import hdc_feeder_pkg::*;
#(
   parameter int FIFO_DEPTH       = 4,
   parameter int SYM_WIDTH        = hdc_feeder_pkg::SYM_WIDTH,
   parameter int CNT_WIDTH        = 16,
   parameter int MAX_WINDOW1_SIZE = hdc_feeder_pkg::MAX_WINDOW1_SIZE
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 soft_reset,
   input  logic                 running,
   input  logic                 sliding_window_mode,
   input  logic [5:0]           window1_size,
   input  logic                 s_valid,
   input  logic [SYM_WIDTH-1:0] s_data,
   input  logic                 s_last,
   output logic                 s_ready,
   output logic                 in_valid,
   output logic [SYM_WIDTH-1:0] in_value,
   input  logic                 in_ready_internal,
   output logic                 sample_done,
   output logic [CNT_WIDTH-1:0] symbol_count,
   output logic                 busy
);

   feeder_state_e        state_q, state_d;
   logic                 credit_q, credit_d;
   logic [5:0]           drain_cnt_q, drain_cnt_d;
   logic [CNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [SYM_WIDTH:0]   fifo_head;
   logic                 head_last;
   logic                 push;
   logic                 issue;
   logic                 issue_ok;
   logic [5:0]           eff_window;

   assign s_ready    = rst_ni && soft_reset && !fifo_full;
   assign push       = s_valid && s_ready;
   assign head_last  = fifo_head[SYM_WIDTH];
   assign in_value   = fifo_head[SYM_WIDTH-1:0];
   assign in_valid   = issue;
   assign eff_window = clamp_window(window1_size, 6'(MAX_WINDOW1_SIZE));

   symbol_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SYM_WIDTH + 1)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .soft_reset (soft_reset),
      .push_i     (push),
      .pop_i      (issue),
      .wdata_i    ({s_last, s_data}),
      .rdata_o    (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // The mapper sits at window position 0 when idle, so the first symbol needs no credit.
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      drain_cnt_d = drain_cnt_q;
      sym_cnt_d   = sym_cnt_q;
      issue_ok    = 1'b0;
      sample_done = 1'b0;

      case (state_q)
         IDLE:    issue_ok = 1'b1;
         STREAM:  issue_ok = sliding_window_mode ? (in_ready_internal || credit_q) : 1'b1;
         default: issue_ok = 1'b0;
      endcase

      issue = running && soft_reset && !fifo_empty && issue_ok;

      if (issue) begin
         credit_d = 1'b0;
         if (sym_cnt_q != '1) begin
            sym_cnt_d = sym_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (head_last) begin
            state_d     = DRAIN;
            drain_cnt_d = sliding_window_mode ? eff_window : 6'd1;
         end else begin
            state_d = STREAM;
         end
      end else if (in_ready_internal) begin
         credit_d = 1'b1;
      end

      case (state_q)
         DRAIN: begin
            if (running) begin
               if (drain_cnt_q <= 6'd1) begin
                  state_d     = DONE;
                  drain_cnt_d = 6'd0;
               end else begin
                  drain_cnt_d = drain_cnt_q - 6'd1;
               end
            end
         end
         DONE: begin
            sample_done = soft_reset;
            credit_d    = 1'b0;
            sym_cnt_d   = '0;
            state_d     = IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         credit_q    <= 1'b0;
         drain_cnt_q <= 6'd0;
         sym_cnt_q   <= '0;
      end else if (!soft_reset) begin
         state_q     <= IDLE;
         credit_q    <= 1'b0;
         drain_cnt_q <= 6'd0;
         sym_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         drain_cnt_q <= drain_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
      end
   end

   assign symbol_count = sym_cnt_q;
   assign busy         = soft_reset && ((state_q != IDLE) || !fifo_empty);

endmodule

// File: tb/tb_input_feeder.sv
// Scoreboard bench for input_feeder: expected symbols are queued as the host
// pushes them and checked whenever the feeder issues to the mapper.
module tb_input_feeder;

   localparam int SW = 6;
   localparam int CW = 16;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          soft_reset;
   logic          running;
   logic          sliding_window_mode;
   logic [5:0]    window1_size;
   logic          s_valid;
   logic [SW-1:0] s_data;
   logic          s_last;
   logic          s_ready;
   logic          in_valid;
   logic [SW-1:0] in_value;
   logic          in_ready_internal;
   logic          sample_done;
   logic [CW-1:0] symbol_count;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [SW-1:0] expQ[$];
   int            issueLog[$];
   int            doneLog[$];
   logic [CW-1:0] doneCount[$];
   logic [SW-1:0] expVal;

   input_feeder dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .soft_reset          (soft_reset),
      .running             (running),
      .sliding_window_mode (sliding_window_mode),
      .window1_size        (window1_size),
      .s_valid             (s_valid),
      .s_data              (s_data),
      .s_last              (s_last),
      .s_ready             (s_ready),
      .in_valid            (in_valid),
      .in_value            (in_value),
      .in_ready_internal   (in_ready_internal),
      .sample_done         (sample_done),
      .symbol_count        (symbol_count),
      .busy                (busy)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Outputs are sampled on the falling edge, well away from the active edge.
   always @(negedge clk_i) begin
      if (in_valid) begin
         issueLog.push_back(cyc);
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_extra: issued %0h with nothing expected", in_value);
         end else begin
            expVal = expQ.pop_front();
            if (in_value !== expVal) begin
               mismatched++;
               $display("[TB] FAIL scoreboard_value: got %0h expected %0h", in_value, expVal);
            end
         end
      end
      if (sample_done) begin
         doneLog.push_back(cyc);
         doneCount.push_back(symbol_count);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clearLogs();
      issueLog.delete();
      doneLog.delete();
      doneCount.delete();
   endtask

   task automatic pushSym(input logic [SW-1:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      expQ.push_back(d);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic waitDone(input int budget, output bit got);
      int n = 0;
      while (doneLog.size() == 0 && n < budget) begin
         tick();
         n++;
      end
      got = (doneLog.size() != 0);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; soft_reset = 1'b1; running = 1'b0; sliding_window_mode = 1'b0;
      window1_size = 6'd4; s_valid = 1'b0; s_data = '0; s_last = 1'b0; in_ready_internal = 1'b0;
      tick(); tick();
      compared++; if (in_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_valid: got %b expected 0", in_valid); end
      compared++; if (sample_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sample_done: got %b expected 0", sample_done); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      compared++; if (symbol_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", symbol_count); end
      compared++; if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_ready: got %b expected 0", s_ready); end
      rst_ni = 1'b1;
      tick();
      compared++; if (s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_s_ready: got %b expected 1", s_ready); end
   endtask

   task automatic test_nonsliding();
      bit got;
      int k;
      sliding_window_mode = 1'b0; in_ready_internal = 1'b1; running = 1'b1;
      clearLogs();
      k = cyc;
      pushSym(6'd3, 1'b0);
      pushSym(6'd7, 1'b0);
      pushSym(6'd9, 1'b1);
      waitDone(30, got);
      in_ready_internal = 1'b0;
      compared++;
      if (!got) begin mismatched++; $display("[TB] FAIL ns_done_timeout: got none expected sample_done"); end
      else if (doneLog[0] !== k + 5) begin mismatched++; $display("[TB] FAIL ns_done_cycle: got %0d expected %0d", doneLog[0] - k, 5); end
      compared++;
      if (issueLog.size() != 3) begin mismatched++; $display("[TB] FAIL ns_issue_count: got %0d expected 3", issueLog.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            compared++;
            if (issueLog[i] !== k + 1 + i) begin mismatched++; $display("[TB] FAIL ns_issue_cycle: got %0d expected %0d", issueLog[i] - k, 1 + i); end
         end
      end
      compared++;
      if (got && doneCount[0] !== 16'd3) begin mismatched++; $display("[TB] FAIL ns_count_at_done: got %0d expected 3", doneCount[0]); end
      compared++; if (symbol_count !== 16'd0) begin mismatched++; $display("[TB] FAIL ns_count_idle: got %0d expected 0", symbol_count); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL ns_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_sliding();
      bit got;
      int k;
      int expIssue[5] = '{1, 4, 9, 14, 19};
      sliding_window_mode = 1'b1; window1_size = 6'd4; in_ready_internal = 1'b0; running = 1'b1;
      clearLogs();
      k = cyc;
      for (int i = 0; i <= 20; i++) begin
         s_valid = (i < 5);
         s_data  = SW'(10 + i);
         s_last  = (i == 4);
         if (i < 5) expQ.push_back(SW'(10 + i));
         in_ready_internal = (i % 5 == 4) && (i < 20);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0; in_ready_internal = 1'b0;
      waitDone(30, got);
      compared++;
      if (issueLog.size() != 5) begin mismatched++; $display("[TB] FAIL sw_issue_count: got %0d expected 5", issueLog.size()); end
      else begin
         for (int i = 0; i < 5; i++) begin
            compared++;
            if (issueLog[i] !== k + expIssue[i]) begin mismatched++; $display("[TB] FAIL sw_issue_cycle: got %0d expected %0d", issueLog[i] - k, expIssue[i]); end
         end
      end
      compared++;
      if (!got) begin mismatched++; $display("[TB] FAIL sw_done_timeout: got none expected sample_done"); end
      else if (doneLog[0] !== k + 24) begin mismatched++; $display("[TB] FAIL sw_done_cycle: got %0d expected 24", doneLog[0] - k); end
      compared++;
      if (got && doneCount[0] !== 16'd5) begin mismatched++; $display("[TB] FAIL sw_count_at_done: got %0d expected 5", doneCount[0]); end
   endtask

   task automatic test_credit();
      bit got;
      int k;
      sliding_window_mode = 1'b1; window1_size = 6'd2; in_ready_internal = 1'b0; running = 1'b1;
      clearLogs();
      k = cyc;
      for (int i = 0; i < 12; i++) begin
         s_valid = (i == 0) || (i == 7) || (i == 8);
         s_data  = (i == 0) ? 6'h11 : (i == 7) ? 6'h2A : 6'h2B;
         s_last  = (i == 8);
         if (s_valid) expQ.push_back(s_data);
         in_ready_internal = (i == 3) || (i == 4);
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0; in_ready_internal = 1'b0;
      compared++;
      if (issueLog.size() != 2) begin mismatched++; $display("[TB] FAIL cr_single_credit: got %0d issues expected 2", issueLog.size()); end
      else begin
         compared++;
         if (issueLog[1] !== k + 8) begin mismatched++; $display("[TB] FAIL cr_credit_issue: got %0d expected 8", issueLog[1] - k); end
      end
      in_ready_internal = 1'b1;
      tick();
      in_ready_internal = 1'b0;
      waitDone(20, got);
      compared++;
      if (!got) begin mismatched++; $display("[TB] FAIL cr_done_timeout: got none expected sample_done"); end
      else if (doneLog[0] !== k + 15) begin mismatched++; $display("[TB] FAIL cr_done_cycle: got %0d expected 15", doneLog[0] - k); end
      compared++;
      if (issueLog.size() != 3 || issueLog[issueLog.size()-1] !== k + 12) begin
         mismatched++; $display("[TB] FAIL cr_pulse_issue: got %0d issues expected 3 with last at 12", issueLog.size());
      end
   endtask

   task automatic test_fifo_full();
      bit got;
      int accepted = 0;
      sliding_window_mode = 1'b1; window1_size = 6'd1; in_ready_internal = 1'b0; running = 1'b0;
      clearLogs();
      for (int c = 0; c < 6; c++) begin
         s_valid = 1'b1;
         s_data  = SW'(6'h30 + accepted);
         s_last  = (accepted == 5);
         compared++;
         if (s_ready !== (accepted < 4)) begin mismatched++; $display("[TB] FAIL ff_s_ready: got %b expected %b after %0d pushes", s_ready, accepted < 4, accepted); end
         if (s_ready) begin expQ.push_back(s_data); accepted++; end
         tick();
      end
      compared++;
      if (issueLog.size() != 0) begin mismatched++; $display("[TB] FAIL ff_stalled_issue: got %0d issues expected 0", issueLog.size()); end
      running = 1'b1; in_ready_internal = 1'b1;
      for (int n = 0; n < 40 && accepted < 6; n++) begin
         s_valid = 1'b1;
         s_data  = SW'(6'h30 + accepted);
         s_last  = (accepted == 5);
         if (s_ready) begin expQ.push_back(s_data); accepted++; end
         tick();
      end
      s_valid = 1'b0; s_last = 1'b0;
      waitDone(30, got);
      in_ready_internal = 1'b0;
      compared++;
      if (accepted != 6 || !got) begin mismatched++; $display("[TB] FAIL ff_complete: got %0d accepted done=%b expected 6 and done", accepted, got); end
      compared++;
      if (issueLog.size() != 6 || expQ.size() != 0) begin mismatched++; $display("[TB] FAIL ff_no_loss: got %0d issues %0d pending expected 6 and 0", issueLog.size(), expQ.size()); end
      compared++;
      if (got && doneCount[0] !== 16'd6) begin mismatched++; $display("[TB] FAIL ff_count_at_done: got %0d expected 6", doneCount[0]); end
   endtask

   task automatic test_soft_reset();
      sliding_window_mode = 1'b1; window1_size = 6'd3; in_ready_internal = 1'b0; running = 1'b1;
      clearLogs();
      pushSym(6'h01, 1'b0);
      pushSym(6'h02, 1'b0);
      pushSym(6'h03, 1'b0);
      tick();
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL sr_busy_before: got %b expected 1", busy); end
      soft_reset = 1'b0;
      #1;
      compared++; if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL sr_s_ready_clear: got %b expected 0", s_ready); end
      tick();
      soft_reset = 1'b1;
      expQ.delete();
      #1;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL sr_busy_after: got %b expected 0", busy); end
      compared++; if (in_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL sr_in_valid_after: got %b expected 0", in_valid); end
      compared++; if (symbol_count !== 16'd0) begin mismatched++; $display("[TB] FAIL sr_count_after: got %0d expected 0", symbol_count); end
      for (int i = 0; i < 8; i++) tick();
      compared++;
      if (issueLog.size() != 1 || doneLog.size() != 0) begin mismatched++; $display("[TB] FAIL sr_discard: got %0d issues %0d done expected 1 and 0", issueLog.size(), doneLog.size()); end
   endtask

   task automatic test_window_edges();
      bit got;
      int k;
      sliding_window_mode = 1'b1; in_ready_internal = 1'b0; running = 1'b1;

      window1_size = 6'd0;
      clearLogs();
      k = cyc;
      pushSym(6'h05, 1'b1);
      waitDone(30, got);
      compared++;
      if (!got || doneLog[0] !== k + 3) begin mismatched++; $display("[TB] FAIL we_zero_window: got done=%b at %0d expected at 3", got, got ? doneLog[0] - k : -1); end

      window1_size = 6'd20;
      clearLogs();
      k = cyc;
      pushSym(6'h06, 1'b1);
      waitDone(40, got);
      compared++;
      if (!got || doneLog[0] !== k + 14) begin mismatched++; $display("[TB] FAIL we_clamp_window: got done=%b at %0d expected at 14", got, got ? doneLog[0] - k : -1); end

      clearLogs();
      k = cyc;
      pushSym(6'h07, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      running = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      compared++;
      if (busy !== 1'b1 || doneLog.size() != 0) begin mismatched++; $display("[TB] FAIL we_freeze: got busy=%b done=%0d expected 1 and 0", busy, doneLog.size()); end
      running = 1'b1;
      waitDone(40, got);
      compared++;
      if (!got || doneLog[0] !== k + 19) begin mismatched++; $display("[TB] FAIL we_freeze_done: got done=%b at %0d expected at 19", got, got ? doneLog[0] - k : -1); end
   endtask

   initial begin
      test_reset();
      test_nonsliding();
      test_sliding();
      test_credit();
      test_fifo_full();
      test_soft_reset();
      test_window_edges();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
